encoder8to3_seq: RTL

- Sequential 8-to-3 encoder; the inverse of the team's 3-to-8 decoder.
- Accepts an 8-bit request vector through a valid/ready handshake.
- Emits the 3-bit index of every set bit, one index per output beat, in priority order.
- Used wherever a one-hot or multi-hot select vector must be turned back into binary indices for downstream logic.

---
 rtl/encoder8to3_seq_if.sv | 22 ++
 rtl/encoder8to3_seq.sv | 89 ++++++++
 2 files changed

// File: rtl/encoder8to3_seq_if.sv
// encoder8to3_seq_if: request/beat handshake bundle for encoder8to3_seq
// Request side: EN, D, in_valid -> in_ready. Beat side: A, out_valid, last, multi (zero) -> out_ready.
// Optional zero signal present when ENC_ZERO_FLAG_EN is defined.
interface encoder8to3_seq_if;
  logic       EN;
  logic [7:0] D;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] A;
  logic       out_valid;
  logic       out_ready;
  logic       last;
  logic       multi;
`ifdef ENC_ZERO_FLAG_EN
  logic       zero;
  modport master(output EN, D, in_valid, out_ready, input in_ready, A, out_valid, last, multi, zero);
  modport slave(input EN, D, in_valid, out_ready, output in_ready, A, out_valid, last, multi, zero);
`else
  modport master(output EN, D, in_valid, out_ready, input in_ready, A, out_valid, last, multi);
  modport slave(input EN, D, in_valid, out_ready, output in_ready, A, out_valid, last, multi);
`endif
endinterface

// File: rtl/encoder8to3_seq.sv
// encoder8to3_seq: sequential 8-to-3 encoder emitting one index beat per set request bit
// Ports: clk, rst (sync active-high), bus (encoder8to3_seq_if.slave).
// Macro ENC_ZERO_FLAG_EN: an accepted all-zero vector yields one beat flagged by bus.zero.
module encoder8to3_seq #(
  parameter bit LSB_FIRST = 1'b0
) (
  input logic                clk,
  input logic                rst,
  encoder8to3_seq_if.slave   bus
);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t     state_q, state_d;
  logic [7:0] pend_q, pend_d, rem;
  logic [2:0] a_q, a_d;
  logic       last_q, last_d, multi_q, multi_d, hs_out, acc;
`ifdef ENC_ZERO_FLAG_EN
  logic       zero_q, zero_d;
`endif
  function automatic logic [2:0] prio(input logic [7:0] v);
    prio = 3'd0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] j;
      j = LSB_FIRST ? 3'(7 - i) : 3'(i);
      if (v[j]) prio = j;
    end
  endfunction
  assign hs_out        = (state_q == DRAIN) && bus.out_ready;
  assign bus.in_ready  = bus.EN && ((state_q == IDLE) || (hs_out && last_q));
  assign acc           = bus.in_valid && bus.in_ready;
  // pending vector after retiring the current beat, if it retires this cycle
  assign rem           = hs_out ? pend_q & ~(8'd1 << a_q) : pend_q;
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.A         = a_q;
  assign bus.last      = last_q;
  assign bus.multi     = multi_q;
`ifdef ENC_ZERO_FLAG_EN
  assign bus.zero      = zero_q;
`endif
  always_comb begin
    state_d = state_q;
    pend_d  = rem;
    a_d     = a_q;
    last_d  = last_q;
    multi_d = multi_q;
`ifdef ENC_ZERO_FLAG_EN
    zero_d  = zero_q;
`endif
    if (acc && |bus.D) begin
      state_d = DRAIN;
      pend_d  = bus.D;
      a_d     = prio(bus.D);
      last_d  = $countones(bus.D) == 1;
      multi_d = $countones(bus.D) > 1;
`ifdef ENC_ZERO_FLAG_EN
      zero_d  = 1'b0;
    end else if (acc) begin
      state_d = DRAIN;
      pend_d  = 8'd0;
      a_d     = 3'd0;
      last_d  = 1'b1;
      multi_d = 1'b0;
      zero_d  = 1'b1;
`endif
    end else if (hs_out && last_q) begin
      state_d = IDLE;
    end else if (hs_out) begin
      a_d     = prio(rem);
      last_d  = $countones(rem) == 1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= 8'd0;
      a_q     <= 3'd0;
      last_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      a_q     <= a_d;
      last_q  <= last_d;
      multi_q <= multi_d;
    end
  end
`ifdef ENC_ZERO_FLAG_EN
  always_ff @(posedge clk) zero_q <= rst ? 1'b0 : zero_d;
`endif
endmodule
